// File: rtl/matrix_scanner.sv
// Multi-channel LED dot-matrix row scanner with a per-frame shadow bitmap.
// Optional macro MATRIX_BLANK_EN blanks the first BLANK_CYCLES cycles of each row slot.
module matrix_scanner #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CHANNELS     = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CHANNELS*ROWS*COLS-1:0] frame,
  output logic [ROWS-1:0]              dot_row,
  output logic [CHANNELS*COLS-1:0]     dot_col,
  output logic                         frame_start
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  if (SCAN_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_params
    $error("matrix_scanner: illegal SCAN_DIV/BLANK_CYCLES combination");
  end

  logic [DIV_W-1:0]              r_div_cnt;
  logic [ROW_W-1:0]              r_row_idx;
  logic [CHANNELS*ROWS*COLS-1:0] r_shadow;
  logic                          r_started;

  logic [DIV_W-1:0]              w_div_nxt;
  logic [ROW_W-1:0]              w_row_nxt;
  logic                          w_wrap;
  logic [CHANNELS*ROWS*COLS-1:0] w_shadow_nxt;
  logic [ROWS-1:0]               w_row_strobe;
  logic [CHANNELS*COLS-1:0]      w_col_data;
  logic                          w_blank;

  // Reset leaves r_started low so the first enabled edge behaves like a frame wrap.
  always_comb begin
    w_div_nxt = r_div_cnt;
    w_row_nxt = r_row_idx;
    w_wrap    = 1'b0;
    if (!r_started) begin
      w_div_nxt = '0;
      w_row_nxt = '0;
      w_wrap    = 1'b1;
    end else if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      w_div_nxt = '0;
      if (r_row_idx == ROW_W'(ROWS - 1)) begin
        w_row_nxt = '0;
        w_wrap    = 1'b1;
      end else begin
        w_row_nxt = r_row_idx + 1'b1;
      end
    end else begin
      w_div_nxt = r_div_cnt + 1'b1;
    end
  end

  assign w_shadow_nxt = w_wrap ? frame : r_shadow;

  // Outputs reflect the position being entered, so row 0 shows the freshly latched frame.
  always_comb begin
    w_row_strobe = ~(ROWS'(1) << (ROWS - 1 - int'(w_row_nxt)));
    w_col_data   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_col_data[c*COLS +: COLS] = w_shadow_nxt[c*ROWS*COLS + int'(w_row_nxt)*COLS +: COLS];
    end
  end

`ifdef MATRIX_BLANK_EN
  assign w_blank = (int'(w_div_nxt) < BLANK_CYCLES);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_row_idx   <= '0;
      r_shadow    <= '0;
      r_started   <= 1'b0;
      dot_row     <= '1;
      dot_col     <= '0;
      frame_start <= 1'b0;
    end else if (enable) begin
      r_div_cnt   <= w_div_nxt;
      r_row_idx   <= w_row_nxt;
      r_shadow    <= w_shadow_nxt;
      r_started   <= 1'b1;
      frame_start <= w_wrap;
      dot_row     <= w_blank ? '1 : w_row_strobe;
      dot_col     <= w_blank ? '0 : w_col_data;
    end else begin
      dot_row     <= '1;
      dot_col     <= '0;
      frame_start <= 1'b0;
    end
  end

endmodule
